// File: rtl/control_unit_if.sv
// control_unit_if: opcode/handshake inputs and decoded control outputs of the
// RV32 decode/control stage.
//   master: drives opcode, in_valid, stall, flush; observes the controls
//   slave : the control unit itself
// Signals
//   opcode[6:0], in_valid, stall, flush                       -> control unit
//   alu_op[1:0], reg_write, mem_read, mem_write, alu_src,
//   mem_to_reg, branch, jump, illegal, out_valid              <- control unit
interface control_unit_if;
  logic [6:0] opcode;
  logic       in_valid;
  logic       stall;
  logic       flush;
  logic [1:0] alu_op;
  logic       reg_write;
  logic       mem_read;
  logic       mem_write;
  logic       alu_src;
  logic       mem_to_reg;
  logic       branch;
  logic       jump;
  logic       illegal;
  logic       out_valid;

  modport master (
    output opcode, in_valid, stall, flush,
    input  alu_op, reg_write, mem_read, mem_write, alu_src, mem_to_reg,
           branch, jump, illegal, out_valid
  );

  modport slave (
    input  opcode, in_valid, stall, flush,
    output alu_op, reg_write, mem_read, mem_write, alu_src, mem_to_reg,
           branch, jump, illegal, out_valid
  );
endinterface

// File: rtl/control_unit.sv
// control_unit: main decode/control unit of the RV32 core. Maps the 7-bit
// opcode to datapath control strobes and, by default, registers them as an
// ID/EX-style control stage with valid, stall and flush.
// Parameters
//   REG_OUT : 1 = registered outputs (1-cycle latency, rst > flush > stall)
//             0 = combinational outputs (clk/rst/stall unused)
// Ports
//   clk  : core clock, rising edge
//   rst  : synchronous reset, active-high
//   bus  : control_unit_if.slave (opcode/in_valid/stall/flush in, controls out)
// Build option
//   CONTROL_EXT_EN : also decode JAL, JALR, LUI, AUIPC; otherwise they are
//                    illegal and jump is tied to 0.
module control_unit #(
  parameter bit REG_OUT = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  control_unit_if.slave bus
);

  typedef enum logic [6:0] {
    OP_RTYPE  = 7'b0110011,
    OP_IALU   = 7'b0010011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_BRANCH = 7'b1100011,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111,
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111
  } opcode_e;

  typedef struct packed {
    logic [1:0] alu_op;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       alu_src;
    logic       mem_to_reg;
    logic       branch;
    logic       jump;
    logic       illegal;
  } ctrl_t;

  ctrl_t dec;
  ctrl_t ctrl_out;
  logic  valid_out;

  always_comb begin
    dec = '0;
    case (bus.opcode)
      OP_RTYPE: begin
        dec.alu_op    = 2'b10;
        dec.reg_write = 1'b1;
      end
      OP_IALU: begin
        dec.alu_op    = 2'b10;
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
      end
      OP_LOAD: begin
        dec.alu_op     = 2'b00;
        dec.reg_write  = 1'b1;
        dec.mem_read   = 1'b1;
        dec.alu_src    = 1'b1;
        dec.mem_to_reg = 1'b1;
      end
      OP_STORE: begin
        dec.alu_op    = 2'b00;
        dec.mem_write = 1'b1;
        dec.alu_src   = 1'b1;
      end
      OP_BRANCH: begin
        dec.alu_op = 2'b01;
        dec.branch = 1'b1;
      end
`ifdef CONTROL_EXT_EN
      OP_JAL: begin
        dec.reg_write = 1'b1;
        dec.jump      = 1'b1;
      end
      OP_JALR: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.jump      = 1'b1;
      end
      OP_LUI: begin
        dec.alu_op    = 2'b11;
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
      end
      OP_AUIPC: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
      end
`endif
      default: dec.illegal = 1'b1;
    endcase
  end

  generate
    if (REG_OUT) begin : g_reg
      ctrl_t ctrl_q, ctrl_d;
      logic  valid_q, valid_d;

      // Flush beats stall; a stalled bubble stays a bubble, so strobes never
      // appear with valid low.
      always_comb begin
        ctrl_d  = ctrl_q;
        valid_d = valid_q;
        if (bus.flush) begin
          ctrl_d  = '0;
          valid_d = 1'b0;
        end else if (bus.stall) begin
          ctrl_d  = ctrl_q;
          valid_d = valid_q;
        end else if (bus.in_valid) begin
          ctrl_d  = dec;
          valid_d = 1'b1;
        end else begin
          ctrl_d  = '0;
          valid_d = 1'b0;
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          ctrl_q  <= '0;
          valid_q <= 1'b0;
        end else begin
          ctrl_q  <= ctrl_d;
          valid_q <= valid_d;
        end
      end

      assign ctrl_out  = ctrl_q;
      assign valid_out = valid_q;
    end else begin : g_comb
      logic live;
      logic unused_inputs;
      assign live          = bus.in_valid & ~bus.flush;
      assign ctrl_out      = live ? dec : '0;
      assign valid_out     = live;
      assign unused_inputs = ^{clk, rst, bus.stall};
    end
  endgenerate

  assign bus.alu_op     = ctrl_out.alu_op;
  assign bus.reg_write  = ctrl_out.reg_write;
  assign bus.mem_read   = ctrl_out.mem_read;
  assign bus.mem_write  = ctrl_out.mem_write;
  assign bus.alu_src    = ctrl_out.alu_src;
  assign bus.mem_to_reg = ctrl_out.mem_to_reg;
  assign bus.branch     = ctrl_out.branch;
  assign bus.jump       = ctrl_out.jump;
  assign bus.illegal    = ctrl_out.illegal;
  assign bus.out_valid  = valid_out;

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed vector bench for control_unit. One instance with
// registered outputs driven from a vector table, one combinational instance
// exercised by a short hand-written sequence. Expected words are packed as
// {alu_op[1:0], reg_write, mem_read, mem_write, alu_src, mem_to_reg, branch,
//  jump, illegal, out_valid}.
module tb_control_unit;

  logic clk;
  logic rst;

  control_unit_if if_r ();
  control_unit_if if_c ();

  control_unit #(.REG_OUT(1'b1)) u_reg (.clk(clk), .rst(rst), .bus(if_r.slave));
  control_unit #(.REG_OUT(1'b0)) u_comb (.clk(clk), .rst(rst), .bus(if_c.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [10:0] got_r, got_c;
  assign got_r = {if_r.alu_op, if_r.reg_write, if_r.mem_read, if_r.mem_write,
                  if_r.alu_src, if_r.mem_to_reg, if_r.branch, if_r.jump,
                  if_r.illegal, if_r.out_valid};
  assign got_c = {if_c.alu_op, if_c.reg_write, if_c.mem_read, if_c.mem_write,
                  if_c.alu_src, if_c.mem_to_reg, if_c.branch, if_c.jump,
                  if_c.illegal, if_c.out_valid};

  localparam logic [10:0] E_ZERO   = 11'b00_000000_0_0_0;
  localparam logic [10:0] E_RTYPE  = 11'b10_100000_0_0_1;
  localparam logic [10:0] E_IALU   = 11'b10_100100_0_0_1;
  localparam logic [10:0] E_LOAD   = 11'b00_110110_0_0_1;
  localparam logic [10:0] E_STORE  = 11'b00_001100_0_0_1;
  localparam logic [10:0] E_BRANCH = 11'b01_000001_0_0_1;
  localparam logic [10:0] E_ILL    = 11'b00_000000_0_1_1;
`ifdef CONTROL_EXT_EN
  localparam logic [10:0] E_JAL    = 11'b00_100000_1_0_1;
  localparam logic [10:0] E_JALR   = 11'b00_100100_1_0_1;
  localparam logic [10:0] E_LUI    = 11'b11_100100_0_0_1;
  localparam logic [10:0] E_AUIPC  = 11'b00_100100_0_0_1;
`else
  localparam logic [10:0] E_JAL    = E_ILL;
  localparam logic [10:0] E_JALR   = E_ILL;
  localparam logic [10:0] E_LUI    = E_ILL;
  localparam logic [10:0] E_AUIPC  = E_ILL;
`endif

  typedef struct {
    logic        rst;
    logic [6:0]  op;
    logic        v;
    logic        st;
    logic        fl;
    logic [10:0] exp;
  } vec_t;

  localparam int unsigned NVEC = 24;
  vec_t vecs [NVEC];

  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;

  task automatic check(input string name, input logic [10:0] got,
                       input logic [10:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, got, exp);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic [6:0] op,
                              input logic v, input logic st, input logic fl,
                              input logic [10:0] exp);
    vec_t x;
    x.rst = r; x.op = op; x.v = v; x.st = st; x.fl = fl; x.exp = exp;
    return x;
  endfunction

  initial begin
    // Registered-instance vectors: inputs applied before an edge, expected
    // output observed just after it.
    vecs[0]  = mk(1, 7'b0110011, 1, 0, 0, E_ZERO);   // reset
    vecs[1]  = mk(1, 7'b0110011, 1, 0, 0, E_ZERO);   // reset
    vecs[2]  = mk(0, 7'b0110011, 1, 0, 0, E_RTYPE);  // first edge after reset
    vecs[3]  = mk(0, 7'b0010011, 1, 0, 0, E_IALU);
    vecs[4]  = mk(0, 7'b0000011, 1, 0, 0, E_LOAD);
    vecs[5]  = mk(0, 7'b0100011, 1, 0, 0, E_STORE);
    vecs[6]  = mk(0, 7'b1100011, 1, 0, 0, E_BRANCH);
    vecs[7]  = mk(0, 7'b1111111, 1, 0, 0, E_ILL);
    vecs[8]  = mk(0, 7'b0000011, 1, 0, 0, E_LOAD);
    vecs[9]  = mk(0, 7'b0100011, 1, 1, 0, E_LOAD);   // stall holds
    vecs[10] = mk(0, 7'b0100011, 1, 1, 0, E_LOAD);
    vecs[11] = mk(0, 7'b0100011, 1, 1, 0, E_LOAD);
    vecs[12] = mk(0, 7'b0100011, 1, 1, 1, E_ZERO);   // flush beats stall
    vecs[13] = mk(0, 7'b0100011, 0, 0, 0, E_ZERO);   // bubble gating
    vecs[14] = mk(0, 7'b0000001, 1, 0, 0, E_ILL);
    vecs[15] = mk(0, 7'b1101111, 1, 0, 0, E_JAL);
    vecs[16] = mk(0, 7'b0110111, 1, 0, 0, E_LUI);
    vecs[17] = mk(0, 7'b1100111, 1, 0, 0, E_JALR);
    vecs[18] = mk(0, 7'b0010111, 1, 0, 0, E_AUIPC);
    vecs[19] = mk(0, 7'b0110011, 1, 0, 0, E_RTYPE);
    vecs[20] = mk(1, 7'b0110011, 1, 1, 0, E_ZERO);   // rst beats stall
    vecs[21] = mk(0, 7'b0110011, 1, 1, 0, E_ZERO);   // stalled bubble stays
    vecs[22] = mk(0, 7'b0110011, 1, 0, 1, E_ZERO);   // flush with valid
    vecs[23] = mk(0, 7'b1100011, 1, 0, 0, E_BRANCH);

    rst = 1'b1;
    if_r.opcode = '0; if_r.in_valid = 1'b0; if_r.stall = 1'b0; if_r.flush = 1'b0;
    if_c.opcode = '0; if_c.in_valid = 1'b0; if_c.stall = 1'b0; if_c.flush = 1'b0;
    @(negedge clk);

    for (int unsigned i = 0; i < NVEC; i++) begin
      rst           = vecs[i].rst;
      if_r.opcode   = vecs[i].op;
      if_r.in_valid = vecs[i].v;
      if_r.stall    = vecs[i].st;
      if_r.flush    = vecs[i].fl;
      @(posedge clk);
      #1;
      check($sformatf("reg_vec%0d", i), got_r, vecs[i].exp);
      @(negedge clk);
    end

    // Registered path: exactly one cycle of latency (output not yet updated
    // before the edge that captures the new opcode).
    rst = 1'b0;
    if_r.opcode = 7'b0000011; if_r.in_valid = 1'b1;
    if_r.stall = 1'b0; if_r.flush = 1'b0;
    #1;
    check("reg_latency_pre", got_r, E_BRANCH);
    @(posedge clk);
    #1;
    check("reg_latency_post", got_r, E_LOAD);

    // Combinational instance: same-cycle response, stall ignored.
    if_c.opcode = 7'b1100011; if_c.in_valid = 1'b1;
    if_c.stall = 1'b1; if_c.flush = 1'b0;
    #1;
    check("comb_branch", got_c, E_BRANCH);
    if_c.flush = 1'b1;
    #1;
    check("comb_flush", got_c, E_ZERO);
    if_c.flush = 1'b0; if_c.stall = 1'b0;
    if_c.opcode = 7'b0100011; if_c.in_valid = 1'b0;
    #1;
    check("comb_bubble", got_c, E_ZERO);
    if_c.in_valid = 1'b1;
    #1;
    check("comb_store", got_c, E_STORE);
    if_c.opcode = 7'b0110100;
    #1;
    check("comb_low_bits_illegal", got_c, E_ILL);
    if_c.opcode = 7'b1101111;
    #1;
    check("comb_jal", got_c, E_JAL);
    if_c.opcode = 7'b0110111;
    #1;
    check("comb_lui", got_c, E_LUI);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/control_unit.md
Name:
control_unit

Overview:
- Main decode/control unit of the RV32 core, sitting between the instruction-fetch/ID boundary and the execute stage.
- Maps the 7-bit instruction opcode to datapath control strobes: ALU op class, register write, memory read/write, ALU operand select, writeback select, branch and jump, plus an illegal-opcode flag.
- By default the decoded controls are registered as an ID/EX-style control stage, with valid, stall and flush.

Parameters:
- REG_OUT, 1: 1 = registered outputs (1-cycle latency); 0 = purely combinational outputs (clk/rst unused; stall ignored).

Ports:
- clk  in  1  core clock, rising edge
- rst  in  1  synchronous reset, active-high
- opcode  in  7  instr[6:0]
- in_valid  in  1  opcode is a real instruction this cycle
- stall  in  1  hold the current output register
- flush  in  1  kill: load a bubble
- alu_op  out  2  00 add (address calc), 01 compare/sub (branch), 10 funct-decoded, 11 pass-B
- reg_write  out  1  write rd
- mem_read  out  1  data memory load
- mem_write  out  1  data memory store
- alu_src  out  1  ALU operand B: 0 = rs2, 1 = immediate
- mem_to_reg  out  1  writeback source: 1 = memory, 0 = ALU
- branch  out  1  conditional branch
- jump  out  1  unconditional jump (0 unless CONTROL_EXT_EN)
- illegal  out  1  valid instruction with undecodable opcode
- out_valid  out  1  outputs describe a live instruction

Behaviour:
Decode table, fields in the order alu_op, reg_write, mem_read, mem_write, alu_src, mem_to_reg, branch:
- 0110011 R-type: 10,1,0,0,0,0,0
- 0010011 I-ALU: 10,1,0,0,1,0,0
- 0000011 LOAD: 00,1,1,0,1,1,0
- 0100011 STORE: 00,0,0,1,1,0,0
- 1100011 BRANCH: 01,0,0,0,0,0,1
- Any other opcode, including opcode[1:0] != 11 and 1111111: all controls 0, jump = 0, illegal = 1.

Output gating:
- When the slot is not live, all control outputs and illegal are 0.
- No write or memory strobe may ever assert with out_valid = 0.

REG_OUT = 1 (registered), evaluated at each rising clk edge in priority order:
- rst: all outputs 0, out_valid = 0.
- else flush: bubble; all outputs 0, out_valid = 0. Flush beats stall.
- else stall: every output holds its value.
- else in_valid: load decode(opcode), out_valid = 1.
- else: bubble.
- Latency is exactly 1 cycle from opcode to outputs.
- rst asserted mid-stream clears the stage on that edge regardless of stall or flush.

REG_OUT = 0 (combinational):
- outputs = decode(opcode) gated by (in_valid & ~flush).
- out_valid = in_valid & ~flush.
- No state; stall ignored.

Optional Feature:
CONTROL_EXT_EN:
- Defined: the remaining RV32I control-flow and upper-immediate opcodes also decode, with illegal = 0. Fields are in the order alu_op, reg_write, mem_read, mem_write, alu_src, mem_to_reg, branch, jump:
  - 1101111 JAL: 00,1,0,0,0,0,0,1
  - 1100111 JALR: 00,1,0,0,1,0,0,1
  - 0110111 LUI: 11,1,0,0,1,0,0,0
  - 0010111 AUIPC: 00,1,0,0,1,0,0,0
- Undefined: these four opcodes fall to the default row (all controls 0, illegal = 1), and jump is tied to 0.

Test Plan:
1. Reset: rst = 1 for 2 cycles with in_valid = 1, opcode = 0110011 -> all outputs 0 and out_valid = 0; first edge after rst deasserts -> alu_op = 10, reg_write = 1, all other controls 0, out_valid = 1.
2. Opcode sweep, one per cycle with in_valid = 1: 0110011, 0010011, 0000011, 0100011, 1100011, 1111111 -> one cycle later, outputs match the table rows in order. For 1111111: all controls 0 and illegal = 1.
3. Stall/flush: LOAD registered, then stall = 1 for 3 cycles while opcode = 0100011 -> LOAD controls (00,1,1,0,1,1,0) held. Then stall = 1 and flush = 1 together -> bubble (all 0, out_valid = 0).
4. Bubble gating: in_valid = 0 with opcode = 0100011 -> mem_write = 0, illegal = 0, out_valid = 0. Separately, opcode = 0000001 with in_valid = 1 -> illegal = 1 and all strobes 0.
5. CONTROL_EXT_EN: JAL -> jump = 1, reg_write = 1; LUI -> alu_op = 11, alu_src = 1. Without the macro, both give illegal = 1 and jump = 0.
6. REG_OUT = 0: opcode = 1100011, in_valid = 1 -> branch = 1 and alu_op = 01 in the same cycle; asserting flush -> all outputs 0 immediately.
